// File: rtl/rhythm_recorder_pkg.sv
// Shared definitions for the rhythm recorder: default map length, FSM states, accuracy codes.
// The state encoding and MAP_LEN default are shared with the datapath's rhythm shifter.
package rhythm_recorder_pkg;

    localparam int MAP_LEN_DEF = 191;
    localparam int PER_W       = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_RECORD = 2'd2,
        ST_DONE   = 2'd3
    } rec_state_t;

    typedef enum logic [1:0] {
        ACC_MISS    = 2'd0,
        ACC_GOOD    = 2'd1,
        ACC_GREAT   = 2'd2,
        ACC_PERFECT = 2'd3
    } accuracy_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
        return (en && (v != 8'hFF)) ? v + 8'd1 : v;
    endfunction

endpackage

// File: rtl/rhythm_recorder_button_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for an active-low push button.
// press_o pulses for one clk on the same edge the debounced level falls.
module rhythm_recorder_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_n_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any sample agreeing with the current level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync2_q;
                press_q <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/rhythm_recorder.sv
// Live rhythm-map recorder: button presses quantised to 8 Hz steps, bit k = step k.
// Optional RECORDER_NEAREST_EN selects nearest-step instead of floor quantisation.
module rhythm_recorder
    import rhythm_recorder_pkg::*;
#(
    parameter int MAP_LEN         = MAP_LEN_DEF,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_W          = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_i,
    input  logic               button_n_i,
    input  logic               arm_n_i,
    output logic [MAP_LEN-1:0] map_out_o,
    output logic               map_valid_o,
    output logic               recording_o,
    output logic [STEP_W-1:0]  step_o,
    output logic [7:0]         note_count_o
);

    logic               press;
    logic               arm;
    logic               arm_n_q;
    rec_state_t         state_q;
    logic [MAP_LEN-1:0] map_q;
    logic               map_valid_q;
    logic [STEP_W-1:0]  step_q;
    logic [7:0]         note_cnt_q;
    logic               pending_q;
    logic               hit_d;

    rhythm_recorder_button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .button_n_i(button_n_i),
        .press_o   (press)
    );

    always_ff @(posedge clk) begin
        if (!rst) arm_n_q <= 1'b1;
        else      arm_n_q <= arm_n_i;
    end

    assign arm   = arm_n_q & ~arm_n_i;
    assign hit_d = pending_q | press;

`ifdef RECORDER_NEAREST_EN
    logic [PER_W-1:0] per_cnt_q;
    logic [PER_W-1:0] period_q;
    logic             period_vld_q;
    logic             seen_tick_q;
    logic             carry_q;
    logic             late;

    // The first tick after reset ends a partial interval, so P is only trusted from the second one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            per_cnt_q    <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            seen_tick_q  <= 1'b0;
        end else if (tick_i) begin
            per_cnt_q   <= '0;
            seen_tick_q <= 1'b1;
            if (seen_tick_q) begin
                period_q     <= per_cnt_q + 1'b1;
                period_vld_q <= 1'b1;
            end
        end else if (per_cnt_q != '1) begin
            per_cnt_q <= per_cnt_q + 1'b1;
        end
    end

    assign late = period_vld_q && (per_cnt_q >= (period_q >> 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            map_q       <= '0;
            map_valid_q <= 1'b0;
            step_q      <= '0;
            note_cnt_q  <= '0;
            pending_q   <= 1'b0;
`ifdef RECORDER_NEAREST_EN
            carry_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_q     <= ST_ARMED;
                        map_q       <= '0;
                        map_valid_q <= 1'b0;
                        step_q      <= '0;
                        note_cnt_q  <= '0;
                        pending_q   <= 1'b0;
`ifdef RECORDER_NEAREST_EN
                        carry_q     <= 1'b0;
`endif
                    end
                end
                ST_ARMED: begin
                    if (arm) begin
                        state_q <= ST_IDLE;
                    end else if (press) begin
                        state_q   <= ST_RECORD;
                        pending_q <= 1'b1;
                        step_q    <= '0;
                    end
                end
                ST_RECORD: begin
                    // Abort beats a coincident tick: nothing is written for the open step.
                    if (arm) begin
                        state_q     <= ST_IDLE;
                        map_valid_q <= 1'b0;
                        pending_q   <= 1'b0;
`ifdef RECORDER_NEAREST_EN
                        carry_q     <= 1'b0;
`endif
                    end else if (tick_i) begin
                        for (int k = 0; k < MAP_LEN; k++) begin
                            if (step_q == STEP_W'(k)) map_q[k] <= hit_d;
                        end
                        note_cnt_q <= sat_inc8(note_cnt_q, hit_d);
                        step_q     <= step_q + 1'b1;
`ifdef RECORDER_NEAREST_EN
                        pending_q  <= carry_q;
                        carry_q    <= 1'b0;
`else
                        pending_q  <= 1'b0;
`endif
                        if (step_q == STEP_W'(MAP_LEN - 1)) begin
                            state_q     <= ST_DONE;
                            map_valid_q <= 1'b1;
                            pending_q   <= 1'b0;
                        end
                    end else if (press) begin
`ifdef RECORDER_NEAREST_EN
                        if (late) carry_q   <= 1'b1;
                        else      pending_q <= 1'b1;
`else
                        pending_q <= 1'b1;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign map_out_o    = map_q;
    assign map_valid_o  = map_valid_q;
    assign recording_o  = (state_q == ST_RECORD);
    assign step_o       = step_q;
    assign note_count_o = note_cnt_q;

endmodule

// File: tb/tb_rhythm_recorder.sv
// Self-checking bench for rhythm_recorder: MAP_LEN=8, DEBOUNCE_CYCLES=4, tick every 20 clk.
// Expected maps come from tap intervals and phases, quantised by the bench's own step model.
module tb_rhythm_recorder;

    localparam int MAP_LEN = 8;
    localparam int DEB     = 4;
    localparam int STEP_W  = 8;
    localparam int PRESS_LAT = 6;
`ifdef RECORDER_NEAREST_EN
    localparam bit NEAREST = 1'b1;
`else
    localparam bit NEAREST = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               tick = 1'b0;
    logic               button_n = 1'b1;
    logic               arm_n = 1'b1;
    logic [MAP_LEN-1:0] map_out;
    logic               map_valid;
    logic               recording;
    logic [STEP_W-1:0]  step;
    logic [7:0]         note_count;

    int checks = 0;
    int errors = 0;
    int period = 20;
    int ph = 0;
    int press_total = 0;

    always #5 clk = ~clk;

    rhythm_recorder #(
        .MAP_LEN(MAP_LEN),
        .DEBOUNCE_CYCLES(DEB),
        .STEP_W(STEP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick),
        .button_n_i  (button_n),
        .arm_n_i     (arm_n),
        .map_out_o   (map_out),
        .map_valid_o (map_valid),
        .recording_o (recording),
        .step_o      (step),
        .note_count_o(note_count)
    );

    always @(posedge clk) if (dut.u_deb.press_o) press_total <= press_total + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // One clk of stimulus; the tick fires on the last cycle of each interval.
    task automatic cyc(input logic btn, input logic arm);
        @(negedge clk);
        button_n = btn;
        arm_n    = arm;
        tick     = (ph == period - 1);
        ph       = (ph == period - 1) ? 0 : ph + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b1);
    endtask

    task automatic do_arm();
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
    endtask

    task automatic sync_step();
        while (ph != 0) cyc(1'b1, 1'b1);
    endtask

    function automatic logic [127:0] tap_at(input int s);
        logic [127:0] m;
        m = '0;
        for (int i = s; i < s + 6; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic run_interval(input logic [127:0] low_mask);
        for (int c = 0; c < period; c++) cyc(!low_mask[c], 1'b1);
    endtask

    // Which step a press lands in, given its interval and the clk phase the debounced press occurs.
    function automatic int qstep(input int interval, input int pulse_ph, input bit first);
        bit late;
        late = !first && (pulse_ph >= period / 2) && (pulse_ph < period - 1);
        return (NEAREST && late) ? interval + 1 : interval;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        checks++; if (map_out !== 8'h00) begin errors++; $display("FAIL reset_map: got %b expected %b", map_out, 8'h00); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", map_valid); end
        checks++; if (step !== 8'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", step); end
        checks++; if (note_count !== 8'd0) begin errors++; $display("FAIL reset_notes: got %0d expected 0", note_count); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL reset_rec: got %b expected 0", recording); end
        rst = 1'b1;
        idle(3 * period);
    endtask

    task automatic test_mid_reset();
        do_arm();
        sync_step();
        for (int j = 0; j < 3; j++) run_interval(tap_at(2));
        cyc(1'b1, 1'b1);
        checks++; if (recording !== 1'b1) begin errors++; $display("FAIL midrst_rec_before: got %b expected 1", recording); end
        checks++; if (note_count !== 8'd3) begin errors++; $display("FAIL midrst_notes_before: got %0d expected 3", note_count); end
        rst = 1'b0;
        cyc(1'b1, 1'b1);
        checks++; if (map_out !== 8'h00) begin errors++; $display("FAIL midrst_map: got %b expected %b", map_out, 8'h00); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", map_valid); end
        checks++; if (step !== 8'd0) begin errors++; $display("FAIL midrst_step: got %0d expected 0", step); end
        checks++; if (note_count !== 8'd0) begin errors++; $display("FAIL midrst_notes: got %0d expected 0", note_count); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL midrst_rec: got %b expected 0", recording); end
        rst = 1'b1;
        idle(3 * period);
    endtask

    task automatic test_pattern();
        logic [7:0] taps;
        logic [7:0] exp_map;
        int q;
        taps = 8'b0010_0101;
        exp_map = '0;
        do_arm();
        sync_step();
        for (int j = 0; j < MAP_LEN; j++) begin
            run_interval(taps[j] ? tap_at(2) : '0);
            if (taps[j]) begin
                q = qstep(j, 2 + PRESS_LAT, j == 0);
                if (q < MAP_LEN) exp_map[q] = 1'b1;
            end
        end
        cyc(1'b1, 1'b1);
        checks++; if (map_out !== exp_map) begin errors++; $display("FAIL pattern_map: got %b expected %b", map_out, exp_map); end
        checks++; if (note_count !== 8'($countones(exp_map))) begin errors++; $display("FAIL pattern_notes: got %0d expected %0d", note_count, $countones(exp_map)); end
        checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL pattern_valid: got %b expected 1", map_valid); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL pattern_rec: got %b expected 0", recording); end
        checks++; if (step !== 8'(MAP_LEN)) begin errors++; $display("FAIL pattern_step: got %0d expected %0d", step, MAP_LEN); end
    endtask

    task automatic test_random();
        logic [7:0] taps;
        logic [7:0] exp_map;
        int start;
        int q;
        for (int it = 0; it < 6; it++) begin
            taps = 8'($urandom);
            taps[0] = 1'b1;
            exp_map = '0;
            do_arm();
            sync_step();
            for (int j = 0; j < MAP_LEN; j++) begin
                start = $urandom_range(0, 3);
                run_interval(taps[j] ? tap_at(start) : '0);
                if (taps[j]) begin
                    q = qstep(j, start + PRESS_LAT, j == 0);
                    if (q < MAP_LEN) exp_map[q] = 1'b1;
                end
            end
            cyc(1'b1, 1'b1);
            checks++; if (map_out !== exp_map) begin errors++; $display("FAIL random_map[%0d]: got %b expected %b", it, map_out, exp_map); end
            checks++; if (note_count !== 8'($countones(exp_map))) begin errors++; $display("FAIL random_notes[%0d]: got %0d expected %0d", it, note_count, $countones(exp_map)); end
            checks++; if (map_valid !== 1'b1) begin errors++; $display("FAIL random_valid[%0d]: got %b expected 1", it, map_valid); end
        end
    endtask

    task automatic test_multi_tap();
        sync_step();
        period = 80;
        idle(80);
        do_arm();
        sync_step();
        run_interval(tap_at(2));
        cyc(1'b1, 1'b1);
        checks++; if (note_count !== 8'd1) begin errors++; $display("FAIL multi_notes_step0: got %0d expected 1", note_count); end
        run_interval(tap_at(1) | tap_at(13) | tap_at(25));
        cyc(1'b1, 1'b1);
        checks++; if (map_out !== 8'b0000_0011) begin errors++; $display("FAIL multi_map: got %b expected %b", map_out, 8'b0000_0011); end
        checks++; if (note_count !== 8'd2) begin errors++; $display("FAIL multi_notes: got %0d expected 2", note_count); end
        do_arm();
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL multi_abort_rec: got %b expected 0", recording); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL multi_abort_valid: got %b expected 0", map_valid); end
        checks++; if (map_out !== 8'b0000_0011) begin errors++; $display("FAIL multi_abort_map: got %b expected %b", map_out, 8'b0000_0011); end
        sync_step();
        period = 20;
        idle(3 * period);
    endtask

    task automatic test_bounce();
        int p0;
        do_arm();
        p0 = press_total;
        repeat (3) cyc(1'b0, 1'b1);
        idle(12);
        checks++; if (press_total - p0 !== 0) begin errors++; $display("FAIL glitch_presses: got %0d expected 0", press_total - p0); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL glitch_rec: got %b expected 0", recording); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
        end
        repeat (8) cyc(1'b0, 1'b1);
        idle(10);
        checks++; if (press_total - p0 !== 1) begin errors++; $display("FAIL bounce_presses: got %0d expected 1", press_total - p0); end
        checks++; if (recording !== 1'b1) begin errors++; $display("FAIL bounce_rec: got %b expected 1", recording); end
        do_arm();
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL bounce_abort_rec: got %b expected 0", recording); end
        idle(2 * period);
    endtask

    task automatic test_simultaneous();
        logic [127:0] m;
        do_arm();
        sync_step();
        for (int j = 0; j < MAP_LEN; j++) begin
            m = (j == 0) ? tap_at(2) : (j == 3) ? tap_at(period - 1 - PRESS_LAT) : '0;
            run_interval(m);
        end
        cyc(1'b1, 1'b1);
        checks++; if (map_out[qstep(3, period - 1, 1'b0)] !== 1'b1) begin errors++; $display("FAIL simul_bit3: got %b expected 1", map_out[3]); end
        checks++; if (map_out[4] !== 1'b0) begin errors++; $display("FAIL simul_bit4: got %b expected 0", map_out[4]); end
        checks++; if (note_count !== 8'd2) begin errors++; $display("FAIL simul_notes: got %0d expected 2", note_count); end
        do_arm();
        sync_step();
        run_interval(tap_at(2));
        run_interval('0);
        m = tap_at(2);
        for (int c = 0; c < period; c++) cyc(!m[c], c != period - 1);
        cyc(1'b1, 1'b1);
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL armtick_rec: got %b expected 0", recording); end
        checks++; if (map_out !== 8'b0000_0001) begin errors++; $display("FAIL armtick_map: got %b expected %b", map_out, 8'b0000_0001); end
        checks++; if (step !== 8'd2) begin errors++; $display("FAIL armtick_step: got %0d expected 2", step); end
        checks++; if (map_valid !== 1'b0) begin errors++; $display("FAIL armtick_valid: got %b expected 0", map_valid); end
        idle(2 * period);
    endtask

    task automatic test_nearest();
        logic [7:0] exp_map;
        int q;
        exp_map = 8'b0000_0001;
        do_arm();
        sync_step();
        run_interval(tap_at(0));
        run_interval(tap_at(15 - PRESS_LAT));
        for (int j = 2; j < MAP_LEN; j++) run_interval('0);
        q = qstep(1, 15, 1'b0);
        exp_map[q] = 1'b1;
        cyc(1'b1, 1'b1);
        checks++; if (map_out !== exp_map) begin errors++; $display("FAIL nearest_map: got %b expected %b", map_out, exp_map); end
        checks++; if (map_out[1] !== !NEAREST) begin errors++; $display("FAIL nearest_bit1: got %b expected %b", map_out[1], !NEAREST); end
        checks++; if (note_count !== 8'd2) begin errors++; $display("FAIL nearest_notes: got %0d expected 2", note_count); end
    endtask

    initial begin
        test_reset();
        test_mid_reset();
        test_pattern();
        test_random();
        test_multi_tap();
        test_bounce();
        test_simultaneous();
        test_nearest();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
